// File: rtl/tic_tac_toe_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tic_tac_toe_game_ctrl                                        |
// | Description : Tic-tac-toe board state, turn order, win/draw detection and  |
// |               winning-line blink mask for the display stage.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tic_tac_toe_game_ctrl #(
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       CLOCK,
  input  logic       reset_n_in,
  input  logic [3:0] cell_cursor,
  input  logic       cell_enter,
  input  logic       new_game,
  output logic [8:0] grid_x,
  output logic [8:0] grid_o,
  output logic [8:0] grid_state_marked,
  output logic       player_o_turn,
  output logic [2:0] game_state,
  output logic [8:0] win_line,
  output logic [8:0] win_blink_mask,
  output logic       illegal_move,
  output logic [3:0] move_count
);

  typedef enum logic [2:0] {
    ST_PLAY  = 3'd0,
    ST_X_WON = 3'd1,
    ST_O_WON = 3'd2,
    ST_DRAW  = 3'd3
  } state_t;

  localparam int c_cnt_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BLINK_DIV - 1);
  localparam logic [8:0] c_lines [0:7] = '{
    9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
  };

  state_t             r_state, w_state_nxt;
  logic [8:0]         r_grid_x, r_grid_o, r_win_line;
  logic [8:0]         w_grid_x_nxt, w_grid_o_nxt, w_win_line_nxt;
  logic               r_turn, r_first_o, r_blink_phase, r_illegal;
  logic               w_turn_nxt, w_first_o_nxt, w_blink_phase_nxt, w_illegal_nxt;
  logic [3:0]         r_move_count, w_move_count_nxt;
  logic [c_cnt_w-1:0] r_blink_cnt, w_blink_cnt_nxt;

  logic [8:0] w_cell, w_marked, w_mover_next, w_hit;
  logic       w_accept, w_won;

  assign w_marked = r_grid_x | r_grid_o;
  assign w_cell   = (cell_cursor <= 4'd8) ? (9'd1 << cell_cursor) : 9'd0;
  assign w_accept = cell_enter && (r_state == ST_PLAY) && (w_cell != 9'd0)
                    && ((w_cell & w_marked) == 9'd0);
  assign w_mover_next = r_turn ? (r_grid_o | w_cell) : (r_grid_x | w_cell);
  assign w_won = (r_state == ST_X_WON) || (r_state == ST_O_WON);

  always_comb begin
    w_hit = 9'd0;
    for (int i = 0; i < 8; i++) begin
      if ((w_mover_next & c_lines[i]) == c_lines[i]) w_hit = w_hit | c_lines[i];
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grid_x_nxt      = r_grid_x;
    w_grid_o_nxt      = r_grid_o;
    w_win_line_nxt    = r_win_line;
    w_turn_nxt        = r_turn;
    w_first_o_nxt     = r_first_o;
    w_move_count_nxt  = r_move_count;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_blink_phase_nxt = r_blink_phase;
    w_illegal_nxt     = 1'b0;
    if (new_game) begin
      // Starter alternates between games; a simultaneous move is dropped silently.
      w_state_nxt       = ST_PLAY;
      w_grid_x_nxt      = 9'd0;
      w_grid_o_nxt      = 9'd0;
      w_win_line_nxt    = 9'd0;
      w_move_count_nxt  = 4'd0;
      w_blink_cnt_nxt   = '0;
      w_blink_phase_nxt = 1'b0;
      w_first_o_nxt     = ~r_first_o;
      w_turn_nxt        = ~r_first_o;
    end else begin
      if (cell_enter && !w_accept) w_illegal_nxt = 1'b1;
      if (w_accept) begin
        if (r_turn) w_grid_o_nxt = w_mover_next;
        else        w_grid_x_nxt = w_mover_next;
        w_move_count_nxt = (r_move_count == 4'd9) ? 4'd9 : r_move_count + 4'd1;
        w_turn_nxt       = ~r_turn;
        if (w_hit != 9'd0) begin
          w_state_nxt    = r_turn ? ST_O_WON : ST_X_WON;
          w_win_line_nxt = w_hit;
        end else if (r_move_count == 4'd8) begin
          w_state_nxt = ST_DRAW;
        end
      end
      if (w_won) begin
        if (r_blink_cnt == c_cnt_max) begin
          w_blink_cnt_nxt   = '0;
          w_blink_phase_nxt = ~r_blink_phase;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state       <= ST_PLAY;
      r_grid_x      <= 9'd0;
      r_grid_o      <= 9'd0;
      r_win_line    <= 9'd0;
      r_turn        <= 1'b0;
      r_first_o     <= 1'b0;
      r_move_count  <= 4'd0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grid_x      <= w_grid_x_nxt;
      r_grid_o      <= w_grid_o_nxt;
      r_win_line    <= w_win_line_nxt;
      r_turn        <= w_turn_nxt;
      r_first_o     <= w_first_o_nxt;
      r_move_count  <= w_move_count_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_blink_phase <= w_blink_phase_nxt;
      r_illegal     <= w_illegal_nxt;
    end
  end

  assign grid_x            = r_grid_x;
  assign grid_o            = r_grid_o;
  assign grid_state_marked = w_marked;
  assign player_o_turn     = r_turn;
  assign game_state        = r_state;
  assign win_line          = r_win_line;
  assign win_blink_mask    = r_blink_phase ? r_win_line : 9'd0;
  assign illegal_move      = r_illegal;
  assign move_count        = r_move_count;

endmodule
`default_nettype wire

// File: tb/tb_tic_tac_toe_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tic_tac_toe_game_ctrl                                     |
// | Description : Scenario and randomized checks against a cell-array model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tic_tac_toe_game_ctrl;
  localparam int BD = 4;

  logic       CLOCK = 1'b0;
  logic       reset_n_in = 1'b0;
  logic [3:0] cell_cursor = 4'd0;
  logic       cell_enter = 1'b0;
  logic       new_game = 1'b0;
  logic [8:0] grid_x, grid_o, grid_state_marked, win_line, win_blink_mask;
  logic       player_o_turn, illegal_move;
  logic [2:0] game_state;
  logic [3:0] move_count;

  tic_tac_toe_game_ctrl #(.BLINK_DIV(BD)) dut (
    .CLOCK(CLOCK), .reset_n_in(reset_n_in), .cell_cursor(cell_cursor),
    .cell_enter(cell_enter), .new_game(new_game), .grid_x(grid_x),
    .grid_o(grid_o), .grid_state_marked(grid_state_marked),
    .player_o_turn(player_o_turn), .game_state(game_state), .win_line(win_line),
    .win_blink_mask(win_blink_mask), .illegal_move(illegal_move),
    .move_count(move_count)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad = 0;

  // Reference model: cell contents 0 empty, 1 X, 2 O; state 0 play, 1 X won, 2 O won, 3 draw.
  int m_cell [9];
  int m_turn, m_first_o, m_state, m_count, m_won_cyc, m_ill;
  logic [8:0] m_win;
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic void model_clear_board();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_count = 0; m_state = 0; m_won_cyc = 0; m_win = '0;
  endfunction

  function automatic void model_reset();
    model_clear_board();
    m_turn = 0; m_first_o = 0; m_ill = 0;
  endfunction

  function automatic void model_edge(bit ent, int cur, bit ng);
    int pre, mk;
    pre = m_state;
    m_ill = 0;
    if (ng) begin
      model_clear_board();
      m_first_o = 1 - m_first_o;
      m_turn = m_first_o;
    end else begin
      if (pre == 1 || pre == 2) m_won_cyc++;
      if (ent) begin
        if (pre == 0 && cur <= 8 && m_cell[cur] == 0) begin
          mk = (m_turn == 1) ? 2 : 1;
          m_cell[cur] = mk;
          m_count++;
          m_turn = 1 - m_turn;
          for (int l = 0; l < 8; l++)
            if (m_cell[lines[l][0]] == mk && m_cell[lines[l][1]] == mk && m_cell[lines[l][2]] == mk)
              m_win = m_win | (9'd1 << lines[l][0]) | (9'd1 << lines[l][1]) | (9'd1 << lines[l][2]);
          if (m_win != 0) m_state = mk;
          else if (m_count == 9) m_state = 3;
        end else begin
          m_ill = 1;
        end
      end
    end
  endfunction

  function automatic logic [53:0] model_vec();
    logic [8:0] gx, go, mask;
    gx = '0; go = '0;
    for (int i = 0; i < 9; i++) begin
      if (m_cell[i] == 1) gx[i] = 1'b1;
      if (m_cell[i] == 2) go[i] = 1'b1;
    end
    mask = ((m_state == 1 || m_state == 2) && ((m_won_cyc / BD) % 2 == 1)) ? m_win : 9'd0;
    return {gx, go, gx | go, m_turn[0], 3'(m_state), m_win, mask, m_ill[0], 4'(m_count)};
  endfunction

  logic [53:0] dut_vec;
  assign dut_vec = {grid_x, grid_o, grid_state_marked, player_o_turn, game_state,
                    win_line, win_blink_mask, illegal_move, move_count};

  task automatic step(input bit ent, input int cur, input bit ng);
    cell_enter = ent; cell_cursor = 4'(cur); new_game = ng;
    @(posedge CLOCK);
    model_edge(ent, cur, ng);
    #1;
    cell_enter = 1'b0; new_game = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLOCK);
    cell_enter = 1'b0; new_game = 1'b0;
    reset_n_in = 1'b0;
    model_reset();
    #2;
    reset_n_in = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({grid_x, grid_o} !== 18'd0) begin bad++; $display("FAIL reset_grid: got %h want 0", {grid_x, grid_o}); end
    total++; if (game_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", game_state); end
    total++; if ({player_o_turn, move_count, illegal_move} !== 6'd0) begin bad++; $display("FAIL reset_turn_count: got %h want 0", {player_o_turn, move_count, illegal_move}); end
    total++; if ({win_line, win_blink_mask} !== 18'd0) begin bad++; $display("FAIL reset_win: got %h want 0", {win_line, win_blink_mask}); end
  endtask

  task automatic test_x_win();
    int seq [5] = '{0, 3, 1, 4, 2};
    apply_reset();
    foreach (seq[i]) step(1, seq[i], 0);
    total++; if ({grid_x, grid_o} !== {9'h007, 9'h018}) begin bad++; $display("FAIL xwin_grid: got %h/%h want 007/018", grid_x, grid_o); end
    total++; if (game_state !== 3'd1) begin bad++; $display("FAIL xwin_state: got %0d want 1", game_state); end
    total++; if (win_line !== 9'h007) begin bad++; $display("FAIL xwin_line: got %h want 007", win_line); end
    total++; if ({move_count, player_o_turn} !== {4'd5, 1'b1}) begin bad++; $display("FAIL xwin_count_turn: got %0d/%0d want 5/1", move_count, player_o_turn); end
    step(0, 0, 0);
    total++; if ({game_state, player_o_turn} !== {3'd1, 1'b1}) begin bad++; $display("FAIL xwin_frozen: got %0d/%0d want 1/1", game_state, player_o_turn); end
  endtask

  task automatic test_blink();
    int seq [5] = '{0, 3, 1, 4, 2};
    logic [8:0] exp;
    apply_reset();
    foreach (seq[i]) step(1, seq[i], 0);
    for (int n = 0; n <= 12; n++) begin
      if (n > 0) step(0, 0, 0);
      exp = ((n / 4) % 2 == 1) ? 9'h007 : 9'h000;
      total++; if (win_blink_mask !== exp) begin bad++; $display("FAIL blink_mask n=%0d: got %h want %h", n, win_blink_mask, exp); end
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    step(1, 0, 0); step(1, 4, 0);
    step(1, 4, 0);
    total++; if (illegal_move !== 1'b1) begin bad++; $display("FAIL illegal_occupied: got %0d want 1", illegal_move); end
    total++; if ({grid_x, grid_o, player_o_turn, move_count} !== {9'h001, 9'h010, 1'b0, 4'd2}) begin bad++; $display("FAIL illegal_occ_nochange: got %h/%h/%0d/%0d", grid_x, grid_o, player_o_turn, move_count); end
    step(0, 0, 0);
    total++; if (illegal_move !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end: got %0d want 0", illegal_move); end
    step(1, 12, 0);
    total++; if ({illegal_move, grid_x, grid_o, move_count} !== {1'b1, 9'h001, 9'h010, 4'd2}) begin bad++; $display("FAIL illegal_cursor12: got %0d %h/%h/%0d", illegal_move, grid_x, grid_o, move_count); end
    step(0, 0, 0);
    total++; if (illegal_move !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end2: got %0d want 0", illegal_move); end
  endtask

  task automatic test_draw();
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    apply_reset();
    foreach (seq[i]) step(1, seq[i], 0);
    total++; if ({game_state, win_line, move_count} !== {3'd3, 9'h000, 4'd9}) begin bad++; $display("FAIL draw_state: got %0d/%h/%0d want 3/000/9", game_state, win_line, move_count); end
    step(1, 0, 0);
    total++; if ({illegal_move, grid_x, grid_o, move_count} !== {1'b1, 9'h18D, 9'h072, 4'd9}) begin bad++; $display("FAIL draw_extra: got %0d %h/%h/%0d", illegal_move, grid_x, grid_o, move_count); end
  endtask

  task automatic test_double_line();
    int seq [9] = '{1, 4, 2, 5, 3, 7, 6, 8, 0};
    apply_reset();
    foreach (seq[i]) step(1, seq[i], 0);
    total++; if ({game_state, win_line, move_count} !== {3'd1, 9'h04F, 4'd9}) begin bad++; $display("FAIL double_line: got %0d/%h/%0d want 1/04f/9", game_state, win_line, move_count); end
  endtask

  task automatic test_new_game_priority();
    apply_reset();
    step(1, 0, 0);
    step(1, 5, 1);
    total++; if ({grid_x, grid_o, game_state, move_count, illegal_move} !== 32'd0) begin bad++; $display("FAIL ng_clear: got %h/%h/%0d/%0d/%0d", grid_x, grid_o, game_state, move_count, illegal_move); end
    total++; if (player_o_turn !== 1'b1) begin bad++; $display("FAIL ng_o_starts: got %0d want 1", player_o_turn); end
    step(1, 5, 0);
    total++; if ({grid_x, grid_o} !== {9'h000, 9'h020}) begin bad++; $display("FAIL ng_o_move: got %h/%h want 000/020", grid_x, grid_o); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(1, 0, 0); step(1, 4, 0);
    @(posedge CLOCK);
    #3;
    reset_n_in = 1'b0;
    model_reset();
    #1;
    total++; if ({grid_x, grid_o, move_count, player_o_turn} !== 23'd0) begin bad++; $display("FAIL async_reset: got %h/%h/%0d/%0d", grid_x, grid_o, move_count, player_o_turn); end
    #2;
    reset_n_in = 1'b1;
  endtask

  task automatic test_random();
    bit ent, ng;
    int cur;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      ng  = ($urandom_range(0, 39) == 0);
      ent = ($urandom_range(0, 1) == 1);
      cur = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      step(ent, cur, ng);
      total++; if (dut_vec !== model_vec()) begin bad++; $display("FAIL random c=%0d: got %h want %h", c, dut_vec, model_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_x_win();
    test_blink();
    test_illegal();
    test_draw();
    test_double_line();
    test_new_game_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
